// File: rtl/gnr_attractor_ctrl.sv
// rtl/gnr_attractor_ctrl.sv - Floyd cycle-detection sequencer for the GNR node array
module gnr_attractor_ctrl #(
    parameter int                   STATE_WIDTH = 8,
    parameter int                   CNT_WIDTH   = 16,
    parameter logic [CNT_WIDTH-1:0] MAX_STEPS   = {CNT_WIDTH{1'b1}}
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [STATE_WIDTH-1:0] init_in,
    input  logic [STATE_WIDTH-1:0] s0_vec,
    input  logic [STATE_WIDTH-1:0] s1_vec,
    output logic                   reset_nos,
    output logic                   start_s0,
    output logic                   start_s1,
    output logic [STATE_WIDTH-1:0] init_state,
    output logic                   busy,
    output logic                   done,
    output logic                   timeout,
    output logic [CNT_WIDTH-1:0]   transient,
    output logic [CNT_WIDTH-1:0]   period,
    output logic [STATE_WIDTH-1:0] attractor
);

    typedef enum logic [3:0] {
        IDLE, LOAD1, MEET, LAMBDA, LOAD2, ADV, MU_A, MU_B, DONE
    } state_t;

    state_t               state, next_state;
    logic [CNT_WIDTH-1:0] cnt;
    logic                 eq;
    logic                 accept;
    logic                 cnt_clr;
    logic                 cnt_inc;
    logic                 ld_period;
    logic                 ld_transient;
    logic                 set_timeout;

    assign eq   = (s0_vec == s1_vec);
    assign done = (state == DONE);
    assign busy = (state != IDLE) && (state != DONE);

    // One step counter serves as m, lam, a and mu; only one phase is live at a time.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            init_state <= '0;
            cnt        <= '0;
            period     <= '0;
            transient  <= '0;
            attractor  <= '0;
            timeout    <= 1'b0;
        end else begin
            state <= next_state;
            if (accept) begin
                init_state <= init_in;
                period     <= '0;
                transient  <= '0;
                attractor  <= '0;
                timeout    <= 1'b0;
            end
            if (cnt_clr)
                cnt <= '0;
            else if (cnt_inc && cnt != MAX_STEPS)
                cnt <= cnt + CNT_WIDTH'(1);
            if (ld_period) begin
                period    <= cnt;
                attractor <= s0_vec;
            end
            if (ld_transient)
                transient <= cnt;
            if (set_timeout)
                timeout <= 1'b1;
        end
    end

    always_comb begin
        next_state   = state;
        reset_nos    = 1'b0;
        start_s0     = 1'b0;
        start_s1     = 1'b0;
        accept       = 1'b0;
        cnt_clr      = 1'b0;
        cnt_inc      = 1'b0;
        ld_period    = 1'b0;
        ld_transient = 1'b0;
        set_timeout  = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    accept     = 1'b1;
                    next_state = LOAD1;
                end
            end
            LOAD1: begin
                reset_nos  = 1'b1;
                cnt_clr    = 1'b1;
                next_state = MEET;
            end
            MEET: begin
                if (!cnt[0] && cnt >= CNT_WIDTH'(2) && eq) begin
                    cnt_clr    = 1'b1;
                    next_state = LAMBDA;
                end else if (cnt == MAX_STEPS) begin
                    set_timeout = 1'b1;
                    next_state  = DONE;
                end else begin
                    start_s0 = 1'b1;
                    start_s1 = 1'b1;
                    cnt_inc  = 1'b1;
                end
            end
            LAMBDA: begin
                if (cnt >= CNT_WIDTH'(1) && eq) begin
                    ld_period  = 1'b1;
                    next_state = LOAD2;
                end else if (cnt == MAX_STEPS) begin
                    set_timeout = 1'b1;
                    next_state  = DONE;
                end else begin
                    start_s1 = 1'b1;
                    cnt_inc  = 1'b1;
                end
            end
            LOAD2: begin
                reset_nos  = 1'b1;
                cnt_clr    = 1'b1;
                next_state = ADV;
            end
            ADV: begin
                if (cnt < period) begin
                    start_s1 = 1'b1;
                    cnt_inc  = 1'b1;
                end else begin
                    cnt_clr    = 1'b1;
                    next_state = MU_A;
                end
            end
            MU_A: begin
                if (eq) begin
                    ld_transient = 1'b1;
                    next_state   = DONE;
                end else if (cnt == MAX_STEPS) begin
                    set_timeout = 1'b1;
                    next_state  = DONE;
                end else begin
                    start_s0   = 1'b1;
                    start_s1   = 1'b1;
                    next_state = MU_B;
                end
            end
            MU_B: begin
                // Second tortoise strobe only flips the node pass bit back to 1.
                start_s0   = 1'b1;
                cnt_inc    = 1'b1;
                next_state = MU_A;
            end
            default: next_state = IDLE;
        endcase
    end

endmodule

// File: tb/tb_gnr_attractor_ctrl.sv
// tb/tb_gnr_attractor_ctrl.sv - directed bench for gnr_attractor_ctrl with behavioural node models
module tb_gnr_attractor_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start1 = 1'b0;
    logic        start2 = 1'b0;
    logic [1:0]  init1 = '0;
    logic [7:0]  init2 = '0;
    int          mode = 0;

    logic [1:0]  s0_1, s1_1, init_state1, attractor1;
    logic        pass1, reset_nos1, start_s0_1, start_s1_1, busy1, done1, timeout1;
    logic [15:0] transient1, period1;

    logic [7:0]  s0_2, s1_2, init_state2, attractor2;
    logic        pass2, reset_nos2, start_s0_2, start_s1_2, busy2, done2, timeout2;
    logic [15:0] transient2, period2;

    logic [2:0]  trace [0:99];
    int          n_assert = 0;
    int          n_fail = 0;
    int          n;
    int          cnt;

    always #5 clk = ~clk;

    gnr_attractor_ctrl #(.STATE_WIDTH(2), .CNT_WIDTH(16)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .init_in(init1),
        .s0_vec(s0_1), .s1_vec(s1_1),
        .reset_nos(reset_nos1), .start_s0(start_s0_1), .start_s1(start_s1_1),
        .init_state(init_state1), .busy(busy1), .done(done1), .timeout(timeout1),
        .transient(transient1), .period(period1), .attractor(attractor1)
    );

    gnr_attractor_ctrl #(.STATE_WIDTH(8), .CNT_WIDTH(16), .MAX_STEPS(16'd5)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .init_in(init2),
        .s0_vec(s0_2), .s1_vec(s1_2),
        .reset_nos(reset_nos2), .start_s0(start_s0_2), .start_s1(start_s1_2),
        .init_state(init_state2), .busy(busy2), .done(done2), .timeout(timeout2),
        .transient(transient2), .period(period2), .attractor(attractor2)
    );

    // mode 0: f(x)=x, mode 1: x+1 mod 4, mode 2: 0->1->2->3->2
    function automatic logic [1:0] f1(input logic [1:0] x, input int md);
        case (md)
            0:       f1 = x;
            1:       f1 = x + 2'd1;
            default: f1 = (x == 2'd3) ? 2'd2 : x + 2'd1;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (reset_nos1) begin
            s0_1  <= init_state1;
            s1_1  <= init_state1;
            pass1 <= 1'b1;
        end else begin
            if (start_s0_1) begin
                if (pass1) s0_1 <= f1(s0_1, mode);
                pass1 <= ~pass1;
            end
            if (start_s1_1) s1_1 <= f1(s1_1, mode);
        end
    end

    always_ff @(posedge clk) begin
        if (reset_nos2) begin
            s0_2  <= init_state2;
            s1_2  <= init_state2;
            pass2 <= 1'b1;
        end else begin
            if (start_s0_2) begin
                if (pass2) s0_2 <= s0_2 + 8'd1;
                pass2 <= ~pass2;
            end
            if (start_s1_2) s1_2 <= s1_2 + 8'd1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run1(input int md, input logic [1:0] iv, input int pulse_idx, output int cyc);
        mode   = md;
        init1  = iv;
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        cyc = 0;
        while (!done1 && cyc < 100) begin
            trace[cyc] = {reset_nos1, start_s0_1, start_s1_1};
            start1 = (cyc == pulse_idx);
            cyc++;
            @(negedge clk);
        end
        start1 = 1'b0;
        check("run1_done_within_bound", {31'd0, done1}, 32'd1);
    endtask

    initial begin
        @(negedge clk);
        @(negedge clk);
        check("rst_busy", {31'd0, busy1}, 32'd0);
        check("rst_done", {31'd0, done1}, 32'd0);
        check("rst_strobes", {29'd0, reset_nos1, start_s0_1, start_s1_1}, 32'd0);
        check("rst_results", {period1, transient1}, 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // fixed point
        run1(0, 2'b10, -1, n);
        check("fp_latency", n, 32'd10);
        check("fp_transient", transient1, 32'd0);
        check("fp_period", period1, 32'd1);
        check("fp_attractor", attractor1, 32'd2);
        check("fp_timeout", timeout1, 32'd0);
        check("fp_busy", busy1, 32'd0);
        cnt = 0;
        for (int i = 0; i < n; i++) if (trace[i][2]) cnt++;
        check("fp_reset_nos_pulses", cnt, 32'd2);

        // pure 4-cycle
        run1(1, 2'b00, -1, n);
        check("cyc_transient", transient1, 32'd0);
        check("cyc_period", period1, 32'd4);
        check("cyc_attractor", attractor1, 32'd0);
        check("cyc_timeout", timeout1, 32'd0);

        // transient of 2 into a 2-cycle
        run1(2, 2'b00, -1, n);
        check("tc_latency", n, 32'd18);
        check("tc_attractor", attractor1, 32'd2);
        check("tc_period", period1, 32'd2);
        check("tc_transient", transient1, 32'd2);
        check("tc_mub_first", trace[14], 32'b010);
        check("tc_mub_second", trace[16], 32'b010);
        cnt = 0;
        for (int i = 0; i < n; i++) if (trace[i] == 3'b010) cnt++;
        check("tc_s0_only_count", cnt, 32'd2);

        // timeout on a never-repeating network
        init2  = 8'd0;
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        n = 0;
        while (!done2 && n < 100) begin
            n++;
            @(negedge clk);
        end
        check("to_done", done2, 32'd1);
        check("to_latency", n, 32'd7);
        check("to_timeout", timeout2, 32'd1);
        check("to_period", period2, 32'd0);
        check("to_transient", transient2, 32'd0);
        for (int i = 0; i < 3; i++) begin
            check("to_no_strobe_after_done", {29'd0, reset_nos2, start_s0_2, start_s1_2}, 32'd0);
            @(negedge clk);
        end

        // reset mid-MEET
        mode   = 2;
        init1  = 2'b01;
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("mid_meet_busy", busy1, 32'd1);
        rst = 1'b0;
        @(negedge clk);
        check("mr_busy", busy1, 32'd0);
        check("mr_done", done1, 32'd0);
        check("mr_strobes", {29'd0, reset_nos1, start_s0_1, start_s1_1}, 32'd0);
        check("mr_init_state", init_state1, 32'd0);
        check("mr_results", {period1, transient1}, 32'd0);
        check("mr_attractor_timeout", {attractor1, timeout1}, 32'd0);
        check("mr_dut2_timeout", timeout2, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("mr_stays_idle", {busy1, reset_nos1, start_s0_1, start_s1_1}, 32'd0);

        // start pulsed during LAMBDA is ignored
        run1(2, 2'b00, 6, n);
        check("ign_latency", n, 32'd18);
        check("ign_attractor", attractor1, 32'd2);
        check("ign_period", period1, 32'd2);
        check("ign_transient", transient1, 32'd2);
        check("ign_timeout", timeout1, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
